// File: rtl/chess_pkg.sv
// Shared chess move definitions: piece codes, move word layout and MVV-LVA scoring.
package chess_pkg;

    localparam int unsigned MW      = 18;
    localparam int unsigned PIECE_W = 3;
    localparam int unsigned SQ_W    = 6;
    localparam int unsigned SCORE_W = 6;

    // Move word field offsets
    localparam int unsigned VICTIM_LSB   = 15;
    localparam int unsigned ATTACKER_LSB = 12;
    localparam int unsigned FROM_LSB     = 6;
    localparam int unsigned TO_LSB       = 0;

    localparam logic [PIECE_W-1:0] P_NONE   = 3'd0;
    localparam logic [PIECE_W-1:0] P_PAWN   = 3'd1;
    localparam logic [PIECE_W-1:0] P_KNIGHT = 3'd2;
    localparam logic [PIECE_W-1:0] P_BISHOP = 3'd3;
    localparam logic [PIECE_W-1:0] P_ROOK   = 3'd4;
    localparam logic [PIECE_W-1:0] P_QUEEN  = 3'd5;
    localparam logic [PIECE_W-1:0] P_KING   = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain,
        StDone
    } coll_state_e;

    // victim*8 + (7 - attacker); a quiet move (victim 0) still ranks by cheapest mover
    function automatic logic [SCORE_W-1:0] move_score(input logic [PIECE_W-1:0] victim,
                                                      input logic [PIECE_W-1:0] attacker);
        return {victim, 3'd7 - attacker};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, registered search pointer.
module rr_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   idx;

    // Search from the pointer; first requester wins, pointer moves just past it
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr_q) + off) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % N);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mvvlva_collector.sv
// Collects candidate moves from the column units and drains them in MVV-LVA order.
module mvvlva_collector #(
    parameter int unsigned N_COL = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned MW    = chess_pkg::MW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    newboard,
    input  logic                    gen_done,
    input  logic [N_COL-1:0]        in_valid,
    input  logic [N_COL*MW-1:0]     in_move,
    output logic [N_COL-1:0]        in_ready,
    output logic                    out_valid,
    output logic [MW-1:0]           out_move,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    list_done,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    import chess_pkg::*;

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    coll_state_e          state_q, state_d;
    logic [DEPTH-1:0]     valid_q;
    logic [MW-1:0]        entry_q [DEPTH];
    logic [CW-1:0]        count_q;
    logic                 overflow_q;

    logic                 collecting;
    logic [N_COL-1:0]     grant;
    logic [MW-1:0]        sel_move;
    logic                 accept, full, store, take;
    logic [IW-1:0]        free_idx;
    logic [IW-1:0]        best_idx;
    logic [SCORE_W-1:0]   best_score, cand_score;
    logic                 best_found;

    // Moves offered in the newboard cycle are refused
    assign collecting = (state_q == StCollect) && !newboard;

    rr_arbiter #(
        .N (N_COL)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (in_valid & {N_COL{collecting}}),
        .grant (grant)
    );

    assign in_ready = grant;
    assign accept   = |grant;
    assign full     = (count_q == CW'(DEPTH));
    // Grant still issues when full so producers never stall; the move is dropped
    assign store    = accept && !full;

    // Mux the granted channel's move word
    always_comb begin
        sel_move = '0;
        for (int i = 0; i < N_COL; i++) begin
            if (grant[i]) sel_move = in_move[i*MW +: MW];
        end
    end

    // Lowest-index free entry
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // Argmax over valid entries; strict compare keeps ties on the lowest index
    always_comb begin
        best_idx   = '0;
        best_score = '0;
        best_found = 1'b0;
        cand_score = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                cand_score = move_score(entry_q[i][VICTIM_LSB +: PIECE_W],
                                        entry_q[i][ATTACKER_LSB +: PIECE_W]);
                if (!best_found || cand_score > best_score) begin
                    best_found = 1'b1;
                    best_score = cand_score;
                    best_idx   = IW'(i);
                end
            end
        end
    end

    assign out_valid = (state_q == StDrain) && (count_q != '0);
    assign out_move  = best_found ? entry_q[best_idx] : '0;
    assign out_last  = out_valid && (count_q == CW'(1));
    assign take      = out_valid && out_ready && !newboard;
    assign list_done = (state_q == StDone);
    assign overflow  = overflow_q;
    assign count     = count_q;

    // Next-state: newboard restarts collection from any state
    always_comb begin
        state_d = state_q;
        if (newboard) begin
            state_d = StCollect;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCollect: begin
                    if (gen_done && (in_valid == '0)) begin
                        state_d = (count_q == '0) ? StDone : StDrain;
                    end
                end
                StDrain: begin
                    if (take && (count_q == CW'(1))) state_d = StDone;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry-valid bits, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (newboard) begin
            valid_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (store) begin
                valid_q[free_idx] <= 1'b1;
                count_q           <= count_q + CW'(1);
            end
            if (accept && full) overflow_q <= 1'b1;
            if (take) begin
                valid_q[best_idx] <= 1'b0;
                count_q           <= count_q - CW'(1);
            end
        end
    end

    // Move payload; qualified by valid_q so no reset needed
    always_ff @(posedge clk) begin
        if (store) entry_q[free_idx] <= sel_move;
    end

endmodule

// File: tb/tb_mvvlva_collector.sv
// Randomized and directed bench for mvvlva_collector against a queue-based reference model.
module tb_mvvlva_collector;

    localparam int N_COL = 8;
    localparam int DEPTH = 64;
    localparam int MW    = 18;
    localparam int PH_IDLE = 0, PH_COL = 1, PH_DRAIN = 2, PH_DONE = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                newboard, gen_done, out_ready;
    logic [N_COL-1:0]    in_valid;
    logic [N_COL*MW-1:0] in_move;
    logic [N_COL-1:0]    in_ready;
    logic                out_valid, out_last, list_done, overflow;
    logic [MW-1:0]       out_move;
    logic [6:0]          count;

    always #5 clk = ~clk;

    mvvlva_collector #(
        .N_COL (N_COL),
        .DEPTH (DEPTH),
        .MW    (MW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .newboard  (newboard),
        .gen_done  (gen_done),
        .in_valid  (in_valid),
        .in_move   (in_move),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_move  (out_move),
        .out_last  (out_last),
        .out_ready (out_ready),
        .list_done (list_done),
        .overflow  (overflow),
        .count     (count)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: moves kept in arrival order; phase and arbiter pointer as plain ints
    int          m_phase;
    int          m_ptr;
    logic        m_ovf;
    logic [17:0] m_q[$];

    // Producers: one pending move per column plus a count of further moves to follow
    logic        pend_v [N_COL];
    logic [17:0] pend_m [N_COL];
    int          pend_n [N_COL];

    logic [17:0] got_moves[$];
    logic        got_last[$];
    logic [7:0]  got_grants[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int score(input logic [17:0] m);
        return int'(m[17:15]) * 8 + 7 - int'(m[14:12]);
    endfunction

    function automatic int best_pos();
        int b = 0;
        for (int i = 1; i < m_q.size(); i++) begin
            if (score(m_q[i]) > score(m_q[b])) b = i;
        end
        return b;
    endfunction

    function automatic logic [17:0] rand_move();
        logic [2:0] v, a;
        logic [5:0] f, t;
        v = 3'($urandom_range(0, 6));
        a = 3'($urandom_range(1, 6));
        f = 6'($urandom);
        t = 6'($urandom);
        return {v, a, f, t};
    endfunction

    function automatic logic any_pending();
        logic p = 1'b0;
        for (int i = 0; i < N_COL; i++) p |= pend_v[i];
        return p;
    endfunction

    task automatic offer(input int col, input logic [17:0] m, input int extra);
        pend_v[col] = 1'b1;
        pend_m[col] = m;
        pend_n[col] = extra;
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_ptr   = 0;
        m_ovf   = 1'b0;
        m_q.delete();
        for (int i = 0; i < N_COL; i++) begin
            pend_v[i] = 1'b0;
            pend_m[i] = '0;
            pend_n[i] = 0;
        end
    endtask

    // One clock: entered and left at a falling edge
    task automatic cycle(input logic nb, input logic gd, input logic ordy);
        logic [7:0]  eg, seen;
        logic        ev;
        int          g;
        newboard  = nb;
        gen_done  = gd;
        out_ready = ordy;
        for (int i = 0; i < N_COL; i++) begin
            in_valid[i]          = pend_v[i];
            in_move[i*MW +: MW]  = pend_m[i];
        end
        #1;
        eg = '0;
        g  = -1;
        if (m_phase == PH_COL && !nb) begin
            for (int k = 0; k < N_COL; k++) begin
                int c;
                c = (m_ptr + k) % N_COL;
                if (in_valid[c]) begin
                    eg[c] = 1'b1;
                    g     = c;
                    break;
                end
            end
        end
        check("in_ready", 32'(in_ready), 32'(eg));
        ev = (m_phase == PH_DRAIN) && (m_q.size() != 0);
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            check("out_move", 32'(out_move), 32'(m_q[best_pos()]));
            check("out_last", 32'(out_last), 32'(m_q.size() == 1));
        end
        seen = in_ready;
        if (seen != '0) got_grants.push_back(seen);
        if (out_valid && out_ready) begin
            got_moves.push_back(out_move);
            got_last.push_back(out_last);
        end
        @(posedge clk);
        if (nb) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_phase = PH_COL;
        end else begin
            case (m_phase)
                PH_COL: begin
                    if (g >= 0) begin
                        m_ptr = (g + 1) % N_COL;
                        if (m_q.size() < DEPTH) m_q.push_back(pend_m[g]);
                        else m_ovf = 1'b1;
                    end
                    if (gd && in_valid == '0) m_phase = (m_q.size() == 0) ? PH_DONE : PH_DRAIN;
                end
                PH_DRAIN: begin
                    if (ev && ordy) begin
                        m_q.delete(best_pos());
                        if (m_q.size() == 0) m_phase = PH_DONE;
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < N_COL; i++) begin
            if (in_valid[i] && seen[i]) begin
                if (pend_n[i] > 0) begin
                    pend_m[i] = rand_move();
                    pend_n[i]--;
                end else begin
                    pend_v[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("count", 32'(count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("list_done", 32'(list_done), 32'(m_phase == PH_DONE));
    endtask

    task automatic drain_all(input int bound, input logic rand_ready);
        int k = 0;
        while (m_phase == PH_DRAIN && k < bound) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            k++;
        end
        check("drain_bound", 32'(m_phase), 32'(PH_DONE));
    endtask

    logic [17:0] mv_pxq, mv_qxp, mv_quiet, mv_r3, mv_r6, mv_c7;

    initial begin
        model_reset();
        rst_n     = 1'b0;
        newboard  = 1'b0;
        gen_done  = 1'b0;
        out_ready = 1'b0;
        in_valid  = '1;
        in_move   = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_list_done", 32'(list_done), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        in_valid = '0;
        rst_n    = 1'b1;

        // gen_done in IDLE is ignored
        cycle(1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of collection
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) offer(i, rand_move(), 0);
        for (int k = 0; k < 20 && any_pending(); k++) cycle(1'b0, 1'b0, 1'b0);
        check("t1_stored", 32'(count), 32'(5));
        in_valid[6] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t1_count", 32'(count), 32'(0));
        check("t1_in_ready", 32'(in_ready), 32'(0));
        check("t1_out_valid", 32'(out_valid), 32'(0));
        check("t1_list_done", 32'(list_done), 32'(0));
        model_reset();
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering: PxQ, QxP, quiet knight offered together before newboard is seen
        mv_pxq   = {3'd5, 3'd1, 6'd12, 6'd51};
        mv_qxp   = {3'd1, 3'd5, 6'd3, 6'd20};
        mv_quiet = {3'd0, 3'd2, 6'd1, 6'd18};
        offer(2, mv_pxq, 0);
        offer(5, mv_qxp, 0);
        offer(0, mv_quiet, 0);
        got_grants.delete();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t2_ngrant", 32'(got_grants.size()), 32'(3));
        check("t2_grant0", 32'(got_grants[0]), 32'(8'h01));
        check("t2_grant1", 32'(got_grants[1]), 32'(8'h04));
        check("t2_grant2", 32'(got_grants[2]), 32'(8'h20));
        cycle(1'b0, 1'b1, 1'b1);
        got_moves.delete();
        got_last.delete();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
        check("t2_nout", 32'(got_moves.size()), 32'(3));
        check("t2_first", 32'(got_moves[0]), 32'(mv_pxq));
        check("t2_second", 32'(got_moves[1]), 32'(mv_qxp));
        check("t2_third", 32'(got_moves[2]), 32'(mv_quiet));
        check("t2_last_early", 32'(got_last[1]), 32'(0));
        check("t2_last", 32'(got_last[2]), 32'(1));
        check("t2_list_done", 32'(list_done), 32'(1));

        // Equal-score rook captures with backpressure
        mv_r3 = {3'd4, 3'd4, 6'd3, 6'd59};
        mv_r6 = {3'd4, 3'd4, 6'd6, 6'd62};
        cycle(1'b1, 1'b0, 1'b0);
        offer(3, mv_r3, 0);
        cycle(1'b0, 1'b0, 1'b0);
        offer(6, mv_r6, 0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("t3_hold", 32'(out_move), 32'(mv_r3));
        end
        got_moves.delete();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("t3_first", 32'(got_moves[0]), 32'(mv_r3));
        check("t3_second", 32'(got_moves[1]), 32'(mv_r6));

        // Overflow: 66 moves from column 1
        cycle(1'b1, 1'b0, 1'b0);
        offer(1, rand_move(), 65);
        for (int k = 0; k < 100 && pend_v[1]; k++) cycle(1'b0, 1'b0, 1'b0);
        check("t4_count", 32'(count), 32'(64));
        check("t4_overflow", 32'(overflow), 32'(1));
        cycle(1'b0, 1'b1, 1'b1);
        got_moves.delete();
        drain_all(100, 1'b0);
        check("t4_drained", 32'(got_moves.size()), 32'(64));

        // Empty board
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("t5_list_done", 32'(list_done), 32'(1));
        check("t5_out_valid", 32'(out_valid), 32'(0));

        // newboard while draining, then a fresh move from column 7
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) offer(i, rand_move(), 0);
        for (int k = 0; k < 20 && any_pending(); k++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("t6_remaining", 32'(count), 32'(3));
        mv_c7 = {3'd2, 3'd3, 6'd7, 6'd9};
        offer(7, mv_c7, 0);
        got_grants.delete();
        cycle(1'b1, 1'b0, 1'b1);
        check("t6_count", 32'(count), 32'(0));
        cycle(1'b0, 1'b0, 1'b0);
        check("t6_grant", 32'(got_grants.size() == 1 ? got_grants[0] : 8'h00), 32'(8'h80));
        check("t6_stored", 32'(count), 32'(1));

        // Randomized boards with random backpressure and occasional mid-drain restarts
        for (int b = 0; b < 25; b++) begin
            logic restarted;
            int   k;
            restarted = 1'b0;
            for (int i = 0; i < N_COL; i++) begin
                if ($urandom_range(0, 2) != 0) offer(i, rand_move(), $urandom_range(0, 3));
            end
            cycle(1'b1, 1'b0, 1'b0);
            k = 0;
            while (m_phase == PH_COL && k < 200) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                k++;
            end
            k = 0;
            while (m_phase == PH_DRAIN && k < 300 && !restarted) begin
                if ($urandom_range(0, 30) == 0) begin
                    restarted = 1'b1;
                    cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                end else begin
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                k++;
            end
            if (!restarted) check("rand_done", 32'(m_phase), 32'(PH_DONE));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
